// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and result channels of the ALU command sequencer.
// The sequencer takes the slave side; the host/ALU/consumer side takes the master side.
interface alu_cmd_sequencer_if #(
  parameter int DEPTH = 4
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic signed [4:0]        cmd_a;
  logic signed [4:0]        cmd_b;
  logic                     cmd_a_en;
  logic                     cmd_b_en;
  logic [2:0]               cmd_a_op;
  logic [1:0]               cmd_b_op;

  logic                     ALU_en;
  logic signed [4:0]        A;
  logic signed [4:0]        B;
  logic                     a_en;
  logic                     b_en;
  logic [2:0]               a_op;
  logic [1:0]               b_op;
  logic signed [5:0]        C;

  logic                     res_valid;
  logic                     res_ready;
  logic signed [5:0]        res_data;
  logic                     res_err;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_a_en, cmd_b_en, cmd_a_op, cmd_b_op,
    input  cmd_ready,
    input  ALU_en, A, B, a_en, b_en, a_op, b_op,
    output C,
    input  res_valid, res_data, res_err,
    output res_ready,
    input  fifo_count
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_a_en, cmd_b_en, cmd_a_op, cmd_b_op,
    output cmd_ready,
    output ALU_en, A, B, a_en, b_en, a_op, b_op,
    input  C,
    output res_valid, res_data, res_err,
    input  res_ready,
    output fifo_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO and issues them one at a time to a registered ALU,
// holding each result until the consumer takes it. Commands with no group enabled are rejected.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  alu_cmd_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic signed [4:0] a;
    logic signed [4:0] b;
    logic              a_en;
    logic              b_en;
    logic [2:0]        a_op;
    logic [1:0]        b_op;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

  cmd_t              mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  cmd_t              head;
  cmd_t              opr_p0;
  logic signed [5:0] res_data_p1;
  logic              res_err_p1;
  logic              vld_p1;
  state_t            state;
  state_t            state_nxt;

  logic push;
  logic pop;
  logic legal_head;
  logic load_opr;
  logic capture;
  logic set_err;
  logic release_res;
  logic alu_en;

  assign bus.cmd_ready = (count != FULL);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign head          = mem[rd_ptr];
  assign legal_head    = head.a_en | head.b_en;

  // Command storage is pure data; only pointers and occupancy are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: bus.cmd_a, b: bus.cmd_b, a_en: bus.cmd_a_en, b_en: bus.cmd_b_en,
                       a_op: bus.cmd_a_op, b_op: bus.cmd_b_op};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = legal_head ? ISSUE : HOLD;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = HOLD;
      HOLD:    if (vld_p1 && bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    load_opr    = 1'b0;
    set_err     = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    alu_en      = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          load_opr = legal_head;
          set_err  = ~legal_head;
        end
      end
      ISSUE:   alu_en      = 1'b1;
      CAPTURE: capture     = 1'b1;
      HOLD:    release_res = vld_p1 && bus.res_ready;
      default: ;
    endcase
  end

  // Stage p0: operand register, loaded only for legal commands so the ALU bus
  // keeps the last issued values across rejected ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           opr_p0 <= '0;
    else if (load_opr) opr_p0 <= head;
  end

  assign bus.ALU_en = alu_en;
  assign bus.A      = opr_p0.a;
  assign bus.B      = opr_p0.b;
  assign bus.a_en   = opr_p0.a_en;
  assign bus.b_en   = opr_p0.b_en;
  assign bus.a_op   = opr_p0.a_op;
  assign bus.b_op   = opr_p0.b_op;

  // Stage p1: result hold register, filled from the ALU or by a rejection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      res_data_p1 <= '0;
      res_err_p1  <= 1'b0;
    end else if (capture) begin
      vld_p1      <= 1'b1;
      res_data_p1 <= bus.C;
      res_err_p1  <= 1'b0;
    end else if (set_err) begin
      vld_p1      <= 1'b1;
      res_data_p1 <= '0;
      res_err_p1  <= 1'b1;
    end else if (release_res) begin
      vld_p1      <= 1'b0;
    end
  end

  assign bus.res_valid  = vld_p1;
  assign bus.res_data   = res_data_p1;
  assign bus.res_err    = res_err_p1;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a table of commands with expected results feeds a
// scoreboard, plus hand-built latency, back-pressure, push/pop and reset sequences.
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 4;

  typedef struct {
    logic signed [4:0] a;
    logic signed [4:0] b;
    logic              a_en;
    logic              b_en;
    logic [2:0]        a_op;
    logic [1:0]        b_op;
    logic signed [5:0] exp_data;
    logic              exp_err;
  } vec_t;

  typedef struct {
    logic signed [5:0] data;
    logic              err;
  } res_t;

  logic clk;
  logic rst;
  alu_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

  alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_chk;
  int   n_pass;
  vec_t tbl [12];
  vec_t iss_q [$];
  res_t exp_q [$];
  vec_t mv;
  res_t mr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  function automatic vec_t mk(input int a, input int b, input bit ae, input bit be,
                              input int aop, input int bop, input int d, input bit e);
    vec_t v;
    v.a = 5'(a); v.b = 5'(b); v.a_en = ae; v.b_en = be;
    v.a_op = 3'(aop); v.b_op = 2'(bop); v.exp_data = 6'(d); v.exp_err = e;
    return v;
  endfunction

  // Registered ALU model: group A has priority, group B otherwise.
  function automatic logic signed [5:0] alu_f(input logic signed [4:0] a, input logic signed [4:0] b,
                                              input logic ae, input logic be,
                                              input logic [2:0] aop, input logic [1:0] bop);
    logic signed [5:0] xa;
    logic signed [5:0] xb;
    logic signed [5:0] r;
    xa = {a[4], a};
    xb = {b[4], b};
    r  = '0;
    if (ae) begin
      case (aop)
        3'd0:    r = xa + xb;
        3'd1:    r = xa - xb;
        3'd2:    r = xa & xb;
        3'd3:    r = xa | xb;
        3'd4:    r = xa ^ xb;
        default: r = '0;
      endcase
    end else if (be) begin
      case (bop)
        2'd0:    r = xb - xa;
        2'd1:    r = xa;
        2'd2:    r = xb;
        default: r = -xb;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.ALU_en) bus.C <= alu_f(bus.A, bus.B, bus.a_en, bus.b_en, bus.a_op, bus.b_op);
  end

  always @(negedge clk) begin
    if (rst) begin
      iss_q.delete();
      exp_q.delete();
    end else begin
      chk("cmd_ready_vs_count", int'(bus.cmd_ready), int'(int'(bus.fifo_count) != DEPTH));
      if (bus.ALU_en) begin
        chk("alu_en_while_res_valid", int'(bus.res_valid), 0);
        if (iss_q.size() == 0) chk("unexpected_issue", 1, 0);
        else begin
          mv = iss_q.pop_front();
          chk("issue_A", int'(bus.A), int'(mv.a));
          chk("issue_B", int'(bus.B), int'(mv.b));
          chk("issue_en", int'({bus.a_en, bus.b_en}), int'({mv.a_en, mv.b_en}));
          chk("issue_ops", int'({bus.a_op, bus.b_op}), int'({mv.a_op, mv.b_op}));
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          mr = exp_q.pop_front();
          chk("res_data", int'(bus.res_data), int'(mr.data));
          chk("res_err", int'(bus.res_err), int'(mr.err));
        end
      end
    end
  end

  task automatic send(input vec_t v);
    int t;
    bus.cmd_a    = v.a;
    bus.cmd_b    = v.b;
    bus.cmd_a_en = v.a_en;
    bus.cmd_b_en = v.b_en;
    bus.cmd_a_op = v.a_op;
    bus.cmd_b_op = v.b_op;
    bus.cmd_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.cmd_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!bus.cmd_ready) chk("send_timeout", 0, 1);
    else begin
      exp_q.push_back('{data: v.exp_data, err: v.exp_err});
      if (v.a_en | v.b_en) iss_q.push_back(v);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && t < 400) begin
      t++;
      @(negedge clk);
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_res_valid(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.res_valid && t < 50) begin
      t++;
      @(negedge clk);
    end
    chk({tag, "_res_valid_seen"}, int'(bus.res_valid), 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_alu_en"},     int'(bus.ALU_en), 0);
    chk({tag, "_res_valid"},  int'(bus.res_valid), 0);
    chk({tag, "_res_data"},   int'(bus.res_data), 0);
    chk({tag, "_res_err"},    int'(bus.res_err), 0);
    chk({tag, "_fifo_count"}, int'(bus.fifo_count), 0);
    chk({tag, "_cmd_ready"},  int'(bus.cmd_ready), 1);
    chk({tag, "_A"},          int'(bus.A), 0);
    chk({tag, "_B"},          int'(bus.B), 0);
    chk({tag, "_en"},         int'({bus.a_en, bus.b_en}), 0);
    chk({tag, "_ops"},        int'({bus.a_op, bus.b_op}), 0);
  endtask

  task automatic no_stale(input string tag);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({tag, "_no_stale_valid"}, int'(bus.res_valid), 0);
    end
    @(posedge clk); #1;
  endtask

  // Measures cycles from the pop edge to res_valid on an idle, empty sequencer.
  task automatic lat_seq(input string tag, input vec_t v, input int exp_lat);
    int first;
    int n_en;
    logic rv [5];
    logic ae [5];
    send(v);
    @(negedge clk);
    chk({tag, "_count_before_pop"}, int'(bus.fifo_count), 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      rv[k] = bus.res_valid;
      ae[k] = bus.ALU_en;
    end
    first = 0;
    n_en  = 0;
    for (int k = 4; k >= 1; k--) begin
      if (rv[k]) first = k;
      if (ae[k]) n_en++;
    end
    chk({tag, "_latency"}, first, exp_lat);
    chk({tag, "_alu_en_pulses"}, n_en, (v.a_en | v.b_en) ? 1 : 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    tbl[0]  = mk(  5,   3, 1, 0, 0, 0,   8, 0);
    tbl[1]  = mk(-16, -16, 1, 0, 0, 0, -32, 0);
    tbl[2]  = mk( 15,  15, 1, 0, 0, 0,  30, 0);
    tbl[3]  = mk(-16,  15, 1, 0, 1, 0, -31, 0);
    tbl[4]  = mk( 15, -16, 1, 0, 1, 0,  31, 0);
    tbl[5]  = mk(  6,   3, 1, 0, 2, 0,   2, 0);
    tbl[6]  = mk(  6,   3, 1, 0, 3, 0,   7, 0);
    tbl[7]  = mk(  6,   3, 1, 0, 4, 0,   5, 0);
    tbl[8]  = mk(  4,  -7, 0, 1, 0, 0, -11, 0);
    tbl[9]  = mk(  0, -16, 0, 1, 0, 3,  16, 0);
    tbl[10] = mk(  9,   2, 0, 0, 5, 1,   0, 1);
    tbl[11] = mk( -1,  -2, 1, 1, 0, 2,  -3, 0);

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_a_en = 1'b0; bus.cmd_b_en = 1'b0;
    bus.cmd_a_op = '0; bus.cmd_b_op = '0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk_reset("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single legal command and a rejected one, with exact latency.
    lat_seq("lat_legal", tbl[0], 3);
    lat_seq("lat_illegal", tbl[10], 1);
    chk("illegal_keeps_A", int'(bus.A), 5);
    chk("illegal_keeps_B", int'(bus.B), 3);

    // Full table back to back with the consumer always ready.
    for (int i = 0; i < 12; i++) send(tbl[i]);
    drain("table");

    // Back-pressure: one in flight plus a full FIFO, an extra push is refused.
    bus.res_ready = 1'b0;
    send(tbl[0]);
    for (int i = 1; i <= 4; i++) send(tbl[i]);
    bus.cmd_a = 5'd1; bus.cmd_b = 5'd1; bus.cmd_a_en = 1'b1; bus.cmd_b_en = 1'b0;
    bus.cmd_a_op = 3'd0; bus.cmd_b_op = 2'd0;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_cmd_ready", int'(bus.cmd_ready), 0);
      chk("full_count", int'(bus.fifo_count), DEPTH);
      chk("hold_res_valid", int'(bus.res_valid), 1);
      chk("hold_res_data", int'(bus.res_data), 8);
      chk("hold_A", int'(bus.A), 5);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    drain("backpressure");
    chk("backpressure_empty", int'(bus.fifo_count), 0);

    // Simultaneous push and pop at two stored entries.
    bus.res_ready = 1'b0;
    send(tbl[5]);
    send(tbl[6]);
    send(tbl[7]);
    wait_res_valid("pushpop");
    chk("pushpop_count_before", int'(bus.fifo_count), 2);
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    send(tbl[8]);
    @(negedge clk);
    chk("pushpop_count_after", int'(bus.fifo_count), 2);
    chk("pushpop_issue", int'(bus.ALU_en), 1);
    @(posedge clk); #1;
    drain("pushpop");

    // Twenty commands wrap the pointers several times.
    for (int i = 0; i < 20; i++) send(tbl[(i * 5) % 12]);
    drain("wrap20");

    // Reset while a command is being issued.
    send(tbl[2]);
    send(tbl[3]);
    begin
      int t;
      t = 0;
      @(negedge clk);
      while (!bus.ALU_en && t < 20) begin
        t++;
        @(negedge clk);
      end
      chk("rst_issue_reached", int'(bus.ALU_en), 1);
    end
    #1 rst = 1'b1;
    #1 chk_reset("rst_issue");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    no_stale("rst_issue");
    send(tbl[0]);
    @(negedge clk);
    chk("first_push_after_rst", int'(bus.fifo_count), 1);
    @(posedge clk); #1;
    drain("after_rst");

    // Reset while a result is held.
    bus.res_ready = 1'b0;
    send(tbl[1]);
    send(tbl[4]);
    wait_res_valid("rst_hold");
    chk("rst_hold_data", int'(bus.res_data), -32);
    #1 rst = 1'b1;
    #1 chk_reset("rst_hold");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    no_stale("rst_hold");
    bus.res_ready = 1'b1;
    no_stale("rst_hold_ready");
    chk("rst_hold_empty", int'(bus.fifo_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth in entries; power of two, 2..16.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 cmd_valid  input  1  host command present.
REQ-005 cmd_ready  output  1  FIFO can accept a command.
REQ-006 cmd_a, cmd_b  input  5 each  signed operands.
REQ-007 cmd_a_en, cmd_b_en  input  1 each  ALU operation-group selects.
REQ-008 cmd_a_op  input  3  ALU a_op; cmd_b_op  input  2  ALU b_op.
REQ-009 ALU_en  output  1  ALU enable, high for exactly one cycle per issue.
REQ-010 A, B  output  5 each  signed; a_en, b_en  output  1 each; a_op  output  3; b_op  output  2; all drive the ALU.
REQ-011 C  input  6  signed ALU result, registered by the ALU, valid the cycle after ALU_en.
REQ-012 res_valid  output  1  result held; res_ready  input  1  consumer accepts.
REQ-013 res_data  output  6  signed captured result; res_err  output  1  command was illegal.
REQ-014 fifo_count  output  $clog2(DEPTH)+1  entries currently stored.

Function
REQ-015 A push SHALL occur when cmd_valid && cmd_ready; cmd_ready SHALL equal (fifo_count != DEPTH), with no pass-through when full.
REQ-016 A pop and a push in the same cycle SHALL both take effect, and fifo_count SHALL stay unchanged.
REQ-017 Read and write pointers SHALL wrap modulo DEPTH.
REQ-018 The FSM SHALL have the states IDLE, ISSUE, CAPTURE and HOLD.
REQ-019 IDLE -> ISSUE: when fifo_count != 0, the FSM SHALL pop the head entry into an operand register at that posedge.
REQ-020 ISSUE SHALL drive ALU_en=1 and drive A, B, a_en, b_en, a_op and b_op from the operand register for one cycle, then go to CAPTURE.
REQ-021 CAPTURE SHALL hold ALU_en=0, register res_data=C and res_err=0 at the posedge ending the state, set res_valid=1, and go to HOLD.
REQ-022 HOLD SHALL keep res_valid, res_data and res_err stable until res_valid && res_ready, then clear res_valid and go to IDLE.
REQ-023 A popped command with cmd_a_en=0 && cmd_b_en=0 is illegal; it SHALL skip ISSUE and CAPTURE and go from IDLE straight to HOLD with res_data=0, res_err=1, and ALU_en SHALL stay 0.
REQ-024 Outside ISSUE, ALU_en SHALL be 0, and A, B, a_en, b_en, a_op and b_op SHALL hold their last issued values.
REQ-025 Latency SHALL be 3 cycles from pop posedge to res_valid=1 for a legal command and 1 cycle for an illegal one.
REQ-026 At most one command SHALL be in flight, and no ALU_en SHALL occur while res_valid=1.
REQ-027 Results SHALL be returned in push order.
REQ-028 When HOLD completes with fifo_count != 0, the FSM SHALL pop the next entry on the following IDLE cycle; IDLE SHALL last exactly one cycle.

Reset
REQ-029 While rst=1, asynchronously: FSM=IDLE; pointers and fifo_count=0; res_valid=0; res_data=0; res_err=0; ALU_en=0; A, B, a_en, b_en, a_op, b_op=0; cmd_ready=1.
REQ-030 Asserting rst mid-operation in any state SHALL discard all FIFO contents and any in-flight or held result, with no ALU_en pulse afterwards.
REQ-031 After rst deasserts, the first push SHALL be accepted on the next posedge.

Verification
REQ-032 Push {a=5, b=3, a_en=1, b_en=0, a_op=0}, res_ready=1 -> one ALU_en pulse with A=5, B=3; with the ALU returning C=8, res_data=8, res_err=0, res_valid 3 cycles after pop.
REQ-033 Push 4 commands with res_ready=0 while the first is being processed -> cmd_ready=0 exactly while fifo_count=4; a 5th push is ignored; releasing res_ready drains all 4 results in order.
REQ-034 Push with a_en=0, b_en=0 -> no ALU_en, res_valid 1 cycle after pop, res_data=0, res_err=1.
REQ-035 Push and pop in the same cycle at fifo_count=2 -> fifo_count stays 2; 20 back-to-back commands wrap the pointers with no loss or reorder.
REQ-036 Assert rst during ISSUE and again during HOLD -> all outputs return to their reset values immediately, fifo_count=0, and no stale res_valid appears after release.
REQ-037 Signed boundaries: a=-16, b=-16, a_en=1, b_en=0, a_op=0, with the ALU returning C=-32 -> res_data=6'b100000 with sign preserved.
